// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - SDRAM device responder with protocol checking
//
// Behavioural model of a 4-bank, burst-length-1 SDRAM as seen from its
// controller, clocked by C14M and reset asynchronously by nRST.
//
// Ports:
//   C14M, nRST                  clock, asynchronous active-low reset
//   CKE, nCS, nRAS, nCAS, nRWE  command pins
//   BA[1:0], RA[11:0]           bank and row/column/mode address
//   DQML, DQMH                  byte masks for the low and high lanes
//   DQin[15:0]                  write data from the controller
//   DQout[15:0], DQoe           read data and its drive enable
//   ModeSet                     a legal mode register load has happened
//   ErrFlag, ErrCode[2:0]       sticky violation flag and first violation code
//   RefCnt[15:0]                accepted auto-refresh count (wraps)
module sdram_responder #(
    parameter int ROWBITS = 2,
    parameter int COLBITS = 8
) (
    input  logic        C14M,
    input  logic        nRST,
    input  logic        CKE,
    input  logic        nCS,
    input  logic        nRAS,
    input  logic        nCAS,
    input  logic        nRWE,
    input  logic [1:0]  BA,
    input  logic [11:0] RA,
    input  logic        DQML,
    input  logic        DQMH,
    input  logic [15:0] DQin,
    output logic [15:0] DQout,
    output logic        DQoe,
    output logic        ModeSet,
    output logic        ErrFlag,
    output logic [2:0]  ErrCode,
    output logic [15:0] RefCnt
);

    localparam int AW    = 2 + ROWBITS + COLBITS;
    localparam int DEPTH = 1 << AW;

    // Bank state
    logic [3:0]               open_q, open_d;
    logic [3:0][ROWBITS-1:0]  row_q, row_d;

    // Mode and status
    logic        mode_q, mode_d;
    logic        cl3_q, cl3_d;      // 0: CAS latency 2, 1: CAS latency 3
    logic        wb_q, wb_d;        // write-burst mode bit, kept but unused
    logic        errflag_q, errflag_d;
    logic [2:0]  errcode_q, errcode_d;
    logic [15:0] ref_q, ref_d;

    // Read pipeline: stage 0 is the output register, a read enters at
    // stage CL-1 so that it reaches stage 0 at edge k+CL-1.
    logic [2:0]        pv_q, pv_d;
    logic [2:0][15:0]  pd_q, pd_d;
    logic [1:0]        mask_q;       // DQM from the previous edge

    // Decode results
    logic            err_hit;
    logic [2:0]      err_code;
    logic            rd_en;
    logic            wr_en;
    logic [AW-1:0]   addr;
    logic [15:0]     rdata;
    logic [15:0]     masked;

    logic [15:0] mem [DEPTH];

    assign addr  = {BA, row_q[BA], RA[COLBITS-1:0]};
    assign rdata = mem[addr];

    // Command decode, violation check and state update
    always_comb begin
        open_d    = open_q;
        row_d     = row_q;
        mode_d    = mode_q;
        cl3_d     = cl3_q;
        wb_d      = wb_q;
        ref_d     = ref_q;
        errflag_d = errflag_q;
        errcode_d = errcode_q;
        err_hit   = 1'b0;
        err_code  = 3'd0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;

        if (CKE && !nCS) begin
            case ({nRAS, nCAS, nRWE})
                3'b111: ;
                3'b110: begin
                    err_hit  = 1'b1;
                    err_code = 3'd7;
                end
                3'b000: begin
                    if (!((RA[6:4] == 3'd2 || RA[6:4] == 3'd3) && RA[2:0] == 3'd0)) begin
                        err_hit  = 1'b1;
                        err_code = 3'd1;
                    end else if (|open_q) begin
                        err_hit  = 1'b1;
                        err_code = 3'd2;
                    end else begin
                        mode_d = 1'b1;
                        cl3_d  = (RA[6:4] == 3'd3);
                        wb_d   = RA[9];
                    end
                end
                default: begin
                    if (!mode_q) begin
                        err_hit  = 1'b1;
                        err_code = 3'd3;
                    end else begin
                        case ({nRAS, nCAS, nRWE})
                            3'b011: begin
                                if (open_q[BA]) begin
                                    err_hit  = 1'b1;
                                    err_code = 3'd4;
                                end else begin
                                    open_d[BA] = 1'b1;
                                    row_d[BA]  = RA[ROWBITS-1:0];
                                end
                            end
                            3'b101, 3'b100: begin
                                if (!open_q[BA]) begin
                                    err_hit  = 1'b1;
                                    err_code = 3'd5;
                                end else begin
                                    rd_en = nRWE;
                                    wr_en = !nRWE;
                                    if (RA[10]) begin
                                        open_d[BA] = 1'b0;
                                    end
                                end
                            end
                            3'b010: begin
                                if (RA[10]) begin
                                    open_d = 4'b0000;
                                end else begin
                                    open_d[BA] = 1'b0;
                                end
                            end
                            3'b001: begin
                                if (|open_q) begin
                                    err_hit  = 1'b1;
                                    err_code = 3'd6;
                                end else begin
                                    ref_d = ref_q + 16'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end

        // Only the first violation is recorded
        if (err_hit && !errflag_q) begin
            errflag_d = 1'b1;
            errcode_d = err_code;
        end
    end

    // Read pipeline advance; masking is applied on entry to the output stage
    always_comb begin
        masked = {mask_q[1] ? 8'h00 : pd_q[1][15:8],
                  mask_q[0] ? 8'h00 : pd_q[1][7:0]};
        pv_d    = {1'b0, pv_q[2], pv_q[1]};
        pd_d[2] = 16'h0000;
        pd_d[1] = pd_q[2];
        pd_d[0] = pv_q[1] ? masked : 16'h0000;
        if (rd_en) begin
            if (cl3_q) begin
                pv_d[2] = 1'b1;
                pd_d[2] = rdata;
            end else begin
                pv_d[1] = 1'b1;
                pd_d[1] = rdata;
            end
        end
    end

    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            open_q    <= 4'b0000;
            row_q     <= '0;
            mode_q    <= 1'b0;
            cl3_q     <= 1'b0;
            wb_q      <= 1'b0;
            errflag_q <= 1'b0;
            errcode_q <= 3'd0;
            ref_q     <= 16'h0000;
            pv_q      <= 3'b000;
            pd_q      <= '0;
            mask_q    <= 2'b00;
        end else begin
            open_q    <= open_d;
            row_q     <= row_d;
            mode_q    <= mode_d;
            cl3_q     <= cl3_d;
            wb_q      <= wb_d;
            errflag_q <= errflag_d;
            errcode_q <= errcode_d;
            ref_q     <= ref_d;
            pv_q      <= pv_d;
            pd_q      <= pd_d;
            mask_q    <= {DQMH, DQML};
        end
    end

    // Storage is deliberately not reset; its contents survive nRST
    always_ff @(posedge C14M) begin
        if (wr_en) begin
            if (!DQML) begin
                mem[addr][7:0] <= DQin[7:0];
            end
            if (!DQMH) begin
                mem[addr][15:8] <= DQin[15:8];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{RA[11], RA[8], wb_q};

    assign DQout   = pd_q[0];
    assign DQoe    = pv_q[0];
    assign ModeSet = mode_q;
    assign ErrFlag = errflag_q;
    assign ErrCode = errcode_q;
    assign RefCnt  = ref_q;

endmodule
